// File: rtl/pipeline_stall_flush_ctrl.sv
// pipeline_stall_flush_ctrl
//   Consumer end of the scoreboard hazard handshake. It turns stall/kill
//   requests into per-stage pipeline-register enables, bubble injects and
//   a PC redirect select for the IF -> ID -> EX -> COMMIT core.
//
//   Outputs are combinational from the current state and inputs, so a
//   request holds the pipe in the same cycle it is seen. State and the
//   remaining-cycle count are registered.
//
// Optional feature: define PERF_CNT_EN to build the saturating stall/flush
//   performance counters. When it is undefined, the counter ports are tied
//   to 0 and no counter flops are built.
//
// Ports
//   clk, nrst        clock (rising edge), async active-low reset
//   stall_i          scoreboard stall request
//   stallnum_i       stall length in cycles (0 = level-held, 1..3)
//   kill_i           scoreboard kill request
//   btaken_i         branch/jump resolved taken in EX
//   pc_en_o          PC register load enable
//   pc_sel_o         1 = load redirect target, 0 = PC+4
//   if_id_en_o       IF/ID register load enable
//   id_ex_en_o       ID/EX register load enable
//   if_id_bubble_o   clear IF/ID valid on next edge
//   id_ex_bubble_o   clear ID/EX valid on next edge
//   state_o          00 RUN, 01 STALL, 10 FLUSH
//   stall_cycles_o   cycles with pc_en_o=0
//   flush_cycles_o   cycles spent in FLUSH
module pipeline_stall_flush_ctrl #(
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             stall_i,
    input  logic [1:0]       stallnum_i,
    input  logic             kill_i,
    input  logic             btaken_i,
    output logic             pc_en_o,
    output logic             pc_sel_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             if_id_bubble_o,
    output logic             id_ex_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_cycles_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    // Remaining FLUSH cycles after the kill cycle itself.
    localparam logic [1:0] FLUSH_REM = 2'(FLUSH_DEPTH - 1);

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic [1:0] rem_dec;
    logic [1:0] stall_rem;
    logic [1:0] stall_nxt;
    logic       kill;

    assign kill      = kill_i | btaken_i;
    assign rem_dec   = (rem_q != 2'd0) ? rem_q - 2'd1 : 2'd0;
    // Cycles still owed after this one for a new stall request.
    assign stall_rem = (stallnum_i != 2'd0) ? stallnum_i - 2'd1 : 2'd0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        if_id_bubble_o = 1'b0;
        id_ex_bubble_o = 1'b0;
        state_d        = RUN;
        rem_d          = 2'd0;
        stall_nxt      = rem_dec;

        if (kill) begin
            // Kill/redirect wins over any stall and aborts a pending one.
            if_id_bubble_o = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                state_d = FLUSH;
                rem_d   = FLUSH_REM;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (stall_i) begin
                        // id_ex_en stays high so the bubble is loaded.
                        pc_en_o        = 1'b0;
                        if_id_en_o     = 1'b0;
                        id_ex_bubble_o = 1'b1;
                        if (stall_rem != 2'd0) begin
                            state_d = STALL;
                            rem_d   = stall_rem;
                        end
                    end
                end
                STALL: begin
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_bubble_o = 1'b1;
                    // A longer new request extends the hold; shorter is ignored.
                    if (stall_i && stall_rem > rem_dec)
                        stall_nxt = stall_rem;
                    if (stall_nxt != 2'd0) begin
                        state_d = STALL;
                        rem_d   = stall_nxt;
                    end
                end
                FLUSH: begin
                    if_id_bubble_o = 1'b1;
                    id_ex_bubble_o = 1'b1;
                    if (rem_dec != 2'd0) begin
                        state_d = FLUSH;
                        rem_d   = rem_dec;
                    end
                end
                default: ;  // encoding 11 recovers to RUN
            endcase
        end
    end

    assign pc_sel_o = btaken_i;
    assign state_o  = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_o && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (state_q == FLUSH && flush_cnt_q != {CNT_W{1'b1}})
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_cycles_o = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_cycles_o = '0;
`endif

endmodule
